seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH_A, default 8, multiplicand width, legal range 2..32.
REQ-002 SHALL have parameter WIDTH_B, default 8, multiplier width and iteration count, legal range 2..32.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port enable, input, 1, global clock-enable; low freezes all state and outputs.
REQ-006 SHALL have port start, input, 1, request to begin a multiplication with the current operands.
REQ-007 SHALL have port sign_mode, input, 1, 0 = unsigned operands, 1 = two's-complement operands; sampled with start.
REQ-008 SHALL have port multiplicand, input, WIDTH_A, operand A; sampled with start.
REQ-009 SHALL have port multiplier, input, WIDTH_B, operand B; sampled with start.
REQ-010 SHALL have port busy, output, 1, high while iterations are in progress.
REQ-011 SHALL have port done, output, 1, single-cycle result-valid strobe.
REQ-012 SHALL have port product, output, WIDTH_A+WIDTH_B, registered result, held between operations.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; transitions occur only on rising edges where enable=1.
REQ-014 SHALL accept start when enable=1, start=1 and state is IDLE or DONE; on accept, capture operands and sign_mode, clear accumulator, set iteration counter to 0, go to RUN.
REQ-015 SHALL ignore start while in RUN; captured operands are unaffected.
REQ-016 SHALL, in RUN, perform one radix-2 shift-add step per enabled edge on magnitudes (one multiplier bit per step, LSB first), incrementing the counter.
REQ-017 SHALL leave RUN for DONE on the enabled edge completing step WIDTH_B, loading product in the same edge.
REQ-018 SHALL, in DONE, assert done=1 for exactly one enabled cycle, then go to IDLE unless a new start is accepted.
REQ-019 SHALL give latency: done=1 in the cycle after the (WIDTH_B+1)th enabled rising edge, counting the accept edge as the first.
REQ-020 SHALL drive busy=1 exactly in RUN; busy and done are never simultaneously high.
REQ-021 SHALL, in signed mode, multiply absolute values in (WIDTH+1)-bit magnitudes so the most negative operand is exact, and negate the result when operand signs differ.
REQ-022 SHALL produce the exact full-width result with no truncation or saturation in both modes.
REQ-023 SHALL keep product unchanged from DONE until the next DONE; product does not change during RUN.
REQ-024 SHALL, when enable=0, hold state, counter, accumulator, busy, done and product; a done cycle stalled by enable=0 remains high until the next enabled edge.
REQ-025 SHALL treat a zero operand as normal, running the full WIDTH_B steps with product 0.

Reset
REQ-026 SHALL, on rst=1, immediately and asynchronously force state IDLE, counter 0, accumulator 0, product 0, busy 0, done 0, regardless of clk or enable.
REQ-027 SHALL abort an in-progress operation on reset without a done strobe; the first enabled edge after rst deasserts may accept start.

Verification
REQ-028 Unsigned: sign_mode=0, A=13, B=11, start pulse, enable=1 -> busy high 8 cycles, done one cycle, product=0x008F (143), latency per REQ-019.
REQ-029 Corners: unsigned 255*255 -> 0xFE01; signed -3*5 (0xFD,0x05) -> 0xFFF1; signed -128*-128 (0x80,0x80) -> 0x4000; signed -128*127 -> 0xC080.
REQ-030 Stall: enable low for 3 cycles mid-RUN and 2 cycles during DONE -> done delayed by exactly 3 cycles and stretched by 2, product 143 unchanged.
REQ-031 Start while busy: second start with A=2, B=2 at step 4 -> ignored, product=143; back-to-back start during done cycle -> accepted, next product=4.
REQ-032 Reset mid-operation: rst pulse at step 5 of 13*11 -> all outputs 0 asynchronously, no done; new start 6*7 -> product=0x002A.

Source files
------------

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier; done strobes WIDTH_B+1 enabled edges after start is accepted.
// enable=0 freezes every register, so done stretches and the operation stalls.
module seq_multiplier #(
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       start,
    input  logic                       sign_mode,
    input  logic [WIDTH_A-1:0]         multiplicand,
    input  logic [WIDTH_B-1:0]         multiplier,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH_A+WIDTH_B-1:0] product
);
    localparam int PW = WIDTH_A + WIDTH_B;
    localparam int CW = $clog2(WIDTH_B + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH_B:0] mplr_q, mplr_d;
    logic            neg_q, neg_d;
    logic [PW-1:0]   product_q, product_d;

    logic [WIDTH_A:0] a_ext, a_mag;
    logic [WIDTH_B:0] b_ext, b_mag;
    logic [PW-1:0]    acc_step;

    // One extra magnitude bit keeps the most negative operand exact.
    always_comb begin
        a_ext = {sign_mode & multiplicand[WIDTH_A-1], multiplicand};
        b_ext = {sign_mode & multiplier[WIDTH_B-1], multiplier};
        a_mag = a_ext[WIDTH_A] ? -a_ext : a_ext;
        b_mag = b_ext[WIDTH_B] ? -b_ext : b_ext;
    end

    assign acc_step = acc_q + (mplr_q[0] ? mcand_q : '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        neg_d     = neg_q;
        product_d = product_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    acc_d   = '0;
                    mcand_d = {{(PW-WIDTH_A-1){1'b0}}, a_mag};
                    mplr_d  = b_mag;
                    neg_d   = a_ext[WIDTH_A] ^ b_ext[WIDTH_B];
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d   = acc_step;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH_B - 1)) begin
                    state_d   = DONE;
                    product_d = neg_q ? -acc_step : acc_step;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else if (enable) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Randomised and directed checks of seq_multiplier against an arithmetic reference product.
module tb_seq_multiplier;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        start;
    logic        sign_mode;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int checks = 0;
    int errors = 0;

    seq_multiplier #(.WIDTH_A(8), .WIDTH_B(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start),
        .sign_mode(sign_mode), .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
        int sa, sb;
        sa = s ? int'($signed(a)) : int'(a);
        sb = s ? int'($signed(b)) : int'(b);
        return 16'(sa * sb);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one operation and observes it until done (bounded); comparisons are left to the caller.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          output logic [15:0] p, output int lat, output int nbusy, output bit ovl);
        multiplicand = a; multiplier = b; sign_mode = s; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0; nbusy = 0; ovl = 1'b0;
        while (!done && lat < 100) begin
            if (busy) nbusy++;
            if (busy && done) ovl = 1'b1;
            tick();
            lat++;
        end
        if (busy && done) ovl = 1'b1;
        p = product;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; start = 1'b0; sign_mode = 1'b0;
        multiplicand = '0; multiplier = '0;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b product=%h, required 0 0 0000", busy, done, product);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] p; int lat, nb; bit ovl;
        run_op(8'd13, 8'd11, 1'b0, p, lat, nb, ovl);
        checks++;
        if (p !== 16'h008F) begin errors++; $display("FAIL basic_product: got %h, required 008f", p); end
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d, required 8", lat); end
        checks++;
        if (nb !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d, required 8", nb); end
        checks++;
        if (ovl) begin errors++; $display("FAIL basic_busy_done_overlap: got 1, required 0"); end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || product !== 16'h008F) begin
            errors++;
            $display("FAIL basic_after_done: done=%b busy=%b product=%h, required 0 0 008f", done, busy, product);
        end
    endtask

    task automatic test_corners();
        logic [7:0]  ca[5] = '{8'hFF, 8'hFD, 8'h80, 8'h80, 8'h00};
        logic [7:0]  cb[5] = '{8'hFF, 8'h05, 8'h80, 8'h7F, 8'hAD};
        logic        cs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [15:0] ce[5] = '{16'hFE01, 16'hFFF1, 16'h4000, 16'hC080, 16'h0000};
        logic [15:0] p; int lat, nb; bit ovl;
        for (int i = 0; i < 5; i++) begin
            run_op(ca[i], cb[i], cs[i], p, lat, nb, ovl);
            checks++;
            if (p !== ce[i] || lat !== 8) begin
                errors++;
                $display("FAIL corner_%0d: product=%h latency=%0d, required %h 8", i, p, lat, ce[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [15:0] p, e; int lat, nb; bit ovl;
        logic [7:0] a, b; logic s;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
            e = ref_mul(a, b, s);
            run_op(a, b, s, p, lat, nb, ovl);
            checks++;
            if (p !== e || lat !== 8 || nb !== 8 || ovl) begin
                errors++;
                $display("FAIL random_%0d: a=%h b=%h s=%b product=%h lat=%0d busy=%0d ovl=%b, required %h 8 8 0",
                         i, a, b, s, p, lat, nb, ovl, e);
            end
            if ($urandom_range(1, 0) == 1) tick();
        end
        tick();
    endtask

    task automatic test_stall();
        int lat, dn; logic [15:0] prev; bit moved;
        prev = product;
        moved = 1'b0;
        multiplicand = 8'd13; multiplier = 8'd11; sign_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            if (lat == 2) enable = 1'b0;
            if (lat == 5) enable = 1'b1;
            if (product !== prev || !busy) moved = 1'b1;
            tick();
            lat++;
        end
        checks++;
        if (lat !== 11) begin errors++; $display("FAIL stall_latency: got %0d, required 11", lat); end
        checks++;
        if (moved) begin errors++; $display("FAIL stall_run_hold: product or busy changed during RUN, required hold"); end
        dn = 1;
        enable = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (done) dn++;
        end
        enable = 1'b1;
        checks++;
        if (dn !== 3 || product !== 16'd143) begin
            errors++;
            $display("FAIL stall_done_stretch: done_cycles=%0d product=%0d, required 3 143", dn, product);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL stall_done_release: done=%b, required 0", done); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] p; int nb; bit ovl;
        multiplicand = 8'd13; multiplier = 8'd11; sign_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            if (lat == 4) begin start = 1'b1; multiplicand = 8'd2; multiplier = 8'd2; end
            else start = 1'b0;
            tick();
            lat++;
        end
        checks++;
        if (product !== 16'd143 || lat !== 8) begin
            errors++;
            $display("FAIL start_while_busy: product=%0d lat=%0d, required 143 8", product, lat);
        end
        run_op(8'd2, 8'd2, 1'b0, p, lat, nb, ovl);
        checks++;
        if (p !== 16'd4 || lat !== 8) begin
            errors++;
            $display("FAIL back_to_back: product=%0d lat=%0d, required 4 8", p, lat);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, nb, seen; logic [15:0] p; bit ovl;
        multiplicand = 8'd13; multiplier = 8'd11; sign_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0) begin
            errors++;
            $display("FAIL reset_async: busy=%b done=%b product=%h, required 0 0 0000", busy, done, product);
        end
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) seen++;
        end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_no_done: activity=%0d, required 0", seen); end
        run_op(8'd6, 8'd7, 1'b0, p, lat, nb, ovl);
        checks++;
        if (p !== 16'h002A || lat !== 8) begin
            errors++;
            $display("FAIL reset_restart: product=%h lat=%0d, required 002a 8", p, lat);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
